// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-port integer register file with bypass and busy scoreboard
//
// Purpose:
//   NREGS x XLEN architectural register file with NREAD combinational read
//   ports and NWRITE write ports. It has an optional hardwired-zero register 0
//   and optional same-cycle write-to-read forwarding. A per-register busy bit
//   tracks pending writebacks: issue logic sets it and writeback clears it.
//
// Ports:
//   clk           in   1             clock, all state updates on rising edge
//   rst           in   1             asynchronous active-high reset
//   read_addr     in   NREAD*AW      packed read addresses, port i at [i*AW +: AW]
//   read_data     out  NREAD*XLEN    packed read data, port i at [i*XLEN +: XLEN]
//   read_busy     out  NREAD         addressed register has a pending writeback
//   write_enable  in   NWRITE        per-port write enable
//   write_addr    in   NWRITE*AW     packed write addresses
//   write_data    in   NWRITE*XLEN   packed write data
//   mark_valid    in   1             mark mark_addr busy (destination allocated)
//   mark_addr     in   AW            register to mark busy

module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     read_addr,
    output logic [NREAD*XLEN-1:0]   read_data,
    output logic [NREAD-1:0]        read_busy,
    input  logic [NWRITE-1:0]       write_enable,
    input  logic [NWRITE*AW-1:0]    write_addr,
    input  logic [NWRITE*XLEN-1:0]  write_data,
    input  logic                    mark_valid,
    input  logic [AW-1:0]           mark_addr
);

    // Index width that exactly spans the storage array. Addresses are range
    // checked before use, so truncating to this width is safe.
    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    // An address names real, writable storage: it is in range and it is not
    // the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < 32'(NREGS)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [IW-1:0] to_idx(input logic [AW-1:0] a);
        return IW'(a);
    endfunction

    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  busy;

    logic [NWRITE-1:0] wr_ok;
    logic [NREGS-1:0]  commit;
    logic [XLEN-1:0]   commit_data [NREGS];
    logic              mark_ok;

    // Read-side scratch, rewritten for every port inside the read loop.
    logic [AW-1:0]     rd_addr;
    logic              rd_hit;
    logic [XLEN-1:0]   rd_byp;
    logic              rd_mark_here;

    // ------------------------------------------------------------------
    // Write decode: a write port only does anything when it is enabled and
    // its address names a writable register.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < NWRITE; j++) begin
            wr_ok[j] = write_enable[j] && addr_ok(write_addr[j*AW +: AW]);
        end
    end

    assign mark_ok = mark_valid && addr_ok(mark_addr);

    // Per-register commit. The port loop runs in ascending order, so when
    // several ports hit the same register the highest-index port's data
    // ends up in commit_data.
    always_comb begin
        commit = '0;
        for (int r = 0; r < NREGS; r++) begin
            commit_data[r] = '0;
        end
        for (int r = 0; r < NREGS; r++) begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_ok[j] && (write_addr[j*AW +: AW] == AW'(r))) begin
                    commit[r]      = 1'b1;
                    commit_data[r] = write_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State: register contents and busy scoreboard
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (commit[r]) begin
                    regs[r] <= commit_data[r];
                end
                // A new producer marking the register takes precedence over
                // the old producer's writeback clearing it.
                if (mark_ok && (mark_addr == AW'(r))) begin
                    busy[r] <= 1'b1;
                end else if (commit[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports
    // ------------------------------------------------------------------
    // Reads are gated by rst so the outputs drop to zero as soon as reset is
    // asserted. This also covers same-cycle write data, which would
    // otherwise be forwarded while reset is held.
    always_comb begin
        read_data    = '0;
        read_busy    = '0;
        rd_addr      = '0;
        rd_hit       = 1'b0;
        rd_byp       = '0;
        rd_mark_here = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            rd_addr = read_addr[i*AW +: AW];
            rd_hit  = 1'b0;
            rd_byp  = '0;
            // Ascending scan keeps the highest-index write port's data.
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_ok[j] && (write_addr[j*AW +: AW] == rd_addr)) begin
                    rd_hit = 1'b1;
                    rd_byp = write_data[j*XLEN +: XLEN];
                end
            end
            rd_mark_here = mark_ok && (mark_addr == rd_addr);
            if (!rst && addr_ok(rd_addr)) begin
                if ((BYPASS != 0) && rd_hit) begin
                    read_data[i*XLEN +: XLEN] = rd_byp;
                end else begin
                    read_data[i*XLEN +: XLEN] = regs[to_idx(rd_addr)];
                end
                // A writeback landing this cycle retires the pending write.
                // If a new producer marks the same register in this cycle,
                // the register stays busy.
                read_busy[i] = busy[to_idx(rd_addr)] &&
                               !((BYPASS != 0) && rd_hit && !rd_mark_here);
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp

module tb_reg_file_mp;

    logic clk;
    logic rst;

    int checks;
    int errors;

    // DUT A: default configuration (bypass on, zero register on)
    logic [9:0]   a_ra;
    logic [63:0]  a_rd;
    logic [1:0]   a_rb;
    logic [1:0]   a_we;
    logic [9:0]   a_wa;
    logic [63:0]  a_wd;
    logic         a_mv;
    logic [4:0]   a_ma;

    // DUT B: bypass off
    logic [9:0]   b_ra;
    logic [63:0]  b_rd;
    logic [1:0]   b_rb;
    logic [1:0]   b_we;
    logic [9:0]   b_wa;
    logic [63:0]  b_wd;
    logic         b_mv;
    logic [4:0]   b_ma;

    // DUT C: 16 registers on a 5-bit address, 4 read ports, 1 write port
    logic [19:0]  c_ra;
    logic [127:0] c_rd;
    logic [3:0]   c_rb;
    logic [0:0]   c_we;
    logic [4:0]   c_wa;
    logic [31:0]  c_wd;
    logic         c_mv;
    logic [4:0]   c_ma;

    // Reference model for DUT A: architectural contents and pending flags
    logic [31:0]  mreg [32];
    bit           mbusy [32];

    reg_file_mp dut_a (
        .clk(clk), .rst(rst),
        .read_addr(a_ra), .read_data(a_rd), .read_busy(a_rb),
        .write_enable(a_we), .write_addr(a_wa), .write_data(a_wd),
        .mark_valid(a_mv), .mark_addr(a_ma)
    );

    reg_file_mp #(.BYPASS(0)) dut_b (
        .clk(clk), .rst(rst),
        .read_addr(b_ra), .read_data(b_rd), .read_busy(b_rb),
        .write_enable(b_we), .write_addr(b_wa), .write_data(b_wd),
        .mark_valid(b_mv), .mark_addr(b_ma)
    );

    reg_file_mp #(.NREGS(16), .NREAD(4), .NWRITE(1)) dut_c (
        .clk(clk), .rst(rst),
        .read_addr(c_ra), .read_data(c_rd), .read_busy(c_rb),
        .write_enable(c_we), .write_addr(c_wa), .write_data(c_wd),
        .mark_valid(c_mv), .mark_addr(c_ma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        a_we = '0; a_wa = '0; a_wd = '0; a_mv = 1'b0; a_ma = '0;
        b_we = '0; b_wa = '0; b_wd = '0; b_mv = 1'b0; b_ma = '0;
        c_we = '0; c_wa = '0; c_wd = '0; c_mv = 1'b0; c_ma = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            mreg[r]  = '0;
            mbusy[r] = 1'b0;
        end
    endtask

    // Randomised traffic on DUT A against the reference model. Addresses
    // are mostly confined to a few registers so that collisions, bypass hits
    // and mark/clear overlaps happen often.
    task automatic run_random(input int ncycles);
        logic [4:0]  ra;
        logic [31:0] hit_data;
        bit          hit;
        logic [31:0] exp_d;
        bit          exp_b;
        bit          clr [32];
        for (int cyc = 0; cyc < ncycles; cyc++) begin
            @(negedge clk);
            a_we = 2'($urandom_range(0, 3));
            a_wa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            if ($urandom_range(0, 3) == 0) a_wa[4:0] = 5'($urandom);
            a_wd = {$urandom, $urandom};
            a_mv = 1'($urandom_range(0, 1));
            a_ma = 5'($urandom_range(0, 7));
            a_ra = {5'($urandom_range(0, 8)), 5'($urandom_range(0, 8))};
            #1;
            for (int i = 0; i < 2; i++) begin
                ra = a_ra[i*5 +: 5];
                hit = 1'b0;
                hit_data = '0;
                for (int j = 0; j < 2; j++) begin
                    if (a_we[j] && a_wa[j*5 +: 5] == ra && ra != 0) begin
                        hit = 1'b1;
                        hit_data = a_wd[j*32 +: 32];
                    end
                end
                if (ra == 0)  exp_d = '0;
                else if (hit) exp_d = hit_data;
                else          exp_d = mreg[ra];
                exp_b = (ra != 0) && mbusy[ra] && !(hit && !(a_mv && a_ma == ra));
                check($sformatf("rnd%0d_rd%0d_x%0d", cyc, i, ra), 64'(a_rd[i*32 +: 32]), 64'(exp_d));
                check($sformatf("rnd%0d_rb%0d_x%0d", cyc, i, ra), 64'(a_rb[i]), 64'(exp_b));
            end
            for (int r = 0; r < 32; r++) clr[r] = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (a_we[j] && a_wa[j*5 +: 5] != 0) begin
                    mreg[a_wa[j*5 +: 5]] = a_wd[j*32 +: 32];
                    clr[a_wa[j*5 +: 5]]  = 1'b1;
                end
            end
            for (int r = 1; r < 32; r++) begin
                if (a_mv && a_ma == 5'(r)) mbusy[r] = 1'b1;
                else if (clr[r])          mbusy[r] = 1'b0;
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        clear_inputs();
        a_ra = {5'd6, 5'd5};
        b_ra = '0;
        c_ra = '0;
        model_reset();
        #3;
        check("reset_a_rd", a_rd, 64'h0);
        check("reset_a_rb", 64'(a_rb), 64'h0);
        check("reset_c_rb", 64'(c_rb), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Write x3 on port 0 and read it on both ports in the same cycle
        @(negedge clk);
        a_we = 2'b01; a_wa = {5'd0, 5'd3}; a_wd = {32'h0, 32'h12345678}; a_ra = {5'd3, 5'd3};
        b_we = 2'b01; b_wa = {5'd0, 5'd3}; b_wd = {32'h0, 32'h12345678}; b_ra = {5'd3, 5'd3};
        #1;
        check("byp_a_x3", a_rd, {32'h12345678, 32'h12345678});
        check("nobyp_b_x3_old", b_rd, 64'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        check("a_x3_next", a_rd, {32'h12345678, 32'h12345678});
        check("b_x3_next", b_rd, {32'h12345678, 32'h12345678});

        // Both write ports target x7: the higher port must win
        @(negedge clk);
        a_we = 2'b11; a_wa = {5'd7, 5'd7}; a_wd = {32'h0000BBBB, 32'hAAAA0000}; a_ra = {5'd3, 5'd7};
        b_we = 2'b11; b_wa = {5'd7, 5'd7}; b_wd = {32'h0000BBBB, 32'hAAAA0000}; b_ra = {5'd3, 5'd7};
        #1;
        check("collide_a_byp", 64'(a_rd[31:0]), 64'h0000BBBB);
        check("collide_b_old", 64'(b_rd[31:0]), 64'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        check("collide_a_x7", 64'(a_rd[31:0]), 64'h0000BBBB);
        check("collide_b_x7", 64'(b_rd[31:0]), 64'h0000BBBB);

        // Write and mark x0: it must stay zero and never busy
        @(negedge clk);
        a_we = 2'b01; a_wa = {5'd0, 5'd0}; a_wd = {32'h0, 32'hFFFFFFFF};
        a_mv = 1'b1; a_ma = 5'd0; a_ra = {5'd0, 5'd0};
        #1;
        check("x0_rd_same", a_rd, 64'h0);
        check("x0_rb_same", 64'(a_rb), 64'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        check("x0_rd_next", a_rd, 64'h0);
        check("x0_rb_next", 64'(a_rb), 64'h0);

        // Busy scoreboard on x9
        @(negedge clk);
        a_mv = 1'b1; a_ma = 5'd9; a_ra = {5'd0, 5'd9};
        #1;
        check("x9_rb_mark_cycle", 64'(a_rb[0]), 64'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        check("x9_rb_marked", 64'(a_rb[0]), 64'h1);
        @(negedge clk);
        a_we = 2'b10; a_wa = {5'd9, 5'd0}; a_wd = {32'h55, 32'h0};
        #1;
        check("x9_rb_clear_byp", 64'(a_rb[0]), 64'h0);
        check("x9_rd_byp", 64'(a_rd[31:0]), 64'h55);
        @(negedge clk);
        clear_inputs();
        #1;
        check("x9_rb_cleared", 64'(a_rb[0]), 64'h0);
        check("x9_rd_55", 64'(a_rd[31:0]), 64'h55);
        @(negedge clk);
        a_we = 2'b01; a_wa = {5'd0, 5'd9}; a_wd = {32'h0, 32'h66}; a_mv = 1'b1; a_ma = 5'd9;
        @(negedge clk);
        clear_inputs();
        #1;
        check("x9_rb_mark_wins", 64'(a_rb[0]), 64'h1);
        check("x9_rd_66", 64'(a_rd[31:0]), 64'h66);
        @(negedge clk);
        a_we = 2'b01; a_wa = {5'd0, 5'd9}; a_wd = {32'h0, 32'h77}; a_mv = 1'b1; a_ma = 5'd9;
        #1;
        check("x9_rb_busy_remark", 64'(a_rb[0]), 64'h1);
        @(negedge clk);
        clear_inputs();
        #1;
        check("x9_rb_still_busy", 64'(a_rb[0]), 64'h1);

        // 16-register instance: out-of-range address and four read ports
        @(negedge clk);
        c_we = 1'b1; c_wa = 5'd20; c_wd = 32'hCAFEF00D; c_mv = 1'b1; c_ma = 5'd20;
        c_ra = {5'd20, 5'd20, 5'd20, 5'd20};
        #1;
        check("c_a20_rd_same", 64'(c_rd[31:0]), 64'h0);
        check("c_a20_rb_same", 64'(c_rb), 64'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        check("c_a20_rd_next", 64'(c_rd[31:0]), 64'h0);
        check("c_a20_rb_next", 64'(c_rb), 64'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            c_we = 1'b1; c_wa = 5'(k); c_wd = 32'h1000 + 32'(k);
        end
        @(negedge clk);
        c_we = 1'b1; c_wa = 5'd15; c_wd = 32'h0F0F0F0F;
        @(negedge clk);
        clear_inputs();
        c_ra = {5'd1, 5'd2, 5'd3, 5'd4};
        #1;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("c_port%0d", p), 64'(c_rd[p*32 +: 32]), 64'(32'h1000 + 32'(4 - p)));
        end
        c_ra = {5'd16, 5'd15, 5'd0, 5'd4};
        #1;
        check("c_x15", 64'(c_rd[64 +: 32]), 64'h0F0F0F0F);
        check("c_a16", 64'(c_rd[96 +: 32]), 64'h0);

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        a_we = 2'b01; a_wa = {5'd0, 5'd5}; a_wd = {32'h0, 32'hDEADBEEF}; a_mv = 1'b1; a_ma = 5'd6;
        @(negedge clk);
        clear_inputs();
        a_ra = {5'd6, 5'd5};
        #1;
        check("pre_rst_x5", 64'(a_rd[31:0]), 64'hDEADBEEF);
        check("pre_rst_x6_busy", 64'(a_rb[1]), 64'h1);
        #2;
        rst = 1'b1;
        a_we = 2'b01; a_wa = {5'd0, 5'd5}; a_wd = {32'h0, 32'h11111111};
        #1;
        check("rst_x5_rd", 64'(a_rd[31:0]), 64'h0);
        check("rst_x6_rb", 64'(a_rb[1]), 64'h0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        model_reset();
        #1;
        check("post_rst_x5", 64'(a_rd[31:0]), 64'h0);

        run_random(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file for the RISC-V core; successor to the fixed 2-read/1-write 32x32 register file. Adds configurable width, depth and port counts, and a hardwired-zero x0. Adds write-to-read bypass and a per-register busy scoreboard, so issue logic can stall on pending writebacks. Sits between decode/issue (reads, busy marking) and writeback (writes, busy clearing).

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of architectural registers; must be ≤ 2**AW.
AW, 5, address width.
NREAD, 2, number of read ports.
NWRITE, 2, number of write ports.
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy.
BYPASS, 1, 1 = same-cycle write data and busy-clear forwarded to read ports.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
read_addr  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
read_data  out  NREAD*XLEN  packed read data, port i at [i*XLEN +: XLEN]
read_busy  out  NREAD  1 = addressed register has a pending writeback
write_enable  in  NWRITE  per-port write enable
write_addr  in  NWRITE*AW  packed write addresses
write_data  in  NWRITE*XLEN  packed write data
mark_valid  in  1  issue marks mark_addr busy (destination allocated)
mark_addr  in  AW  register to mark busy

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst). While rst=1, all registers = 0 and all busy bits = 0 immediately. read_data reflects zeros and read_busy=0 combinationally; this holds even mid-operation. First write takes effect on the first rising edge after rst deasserts.
- Reads are combinational, 0-cycle latency. Address ≥ NREGS: read_data=0, read_busy=0.
- Writes commit on rising clk when write_enable[j]=1 and the address is valid (< NREGS and not reg 0 when ZERO_REG=1). Otherwise ignored.
- Write collision: several ports write the same address in one cycle -> highest-index port wins.
- Bypass (BYPASS=1): if any enabled, valid write port targets read_addr[i] this cycle, read_data[i] = that write_data, using the same highest-index priority. With BYPASS=0, read_data[i] shows the old value until the next cycle.
- Busy scoreboard: one bit per register.
  - Set on the clk edge when mark_valid=1 and mark_addr is valid.
  - Cleared on the clk edge by any committed write to that register.
  - Mark and clear of the same register in the same cycle -> stays busy (new producer wins).
  - Marking an already-busy register: stays busy, no count.
  - Reg 0 with ZERO_REG=1 is never busy.
- read_busy[i] = busy[read_addr[i]]. With BYPASS=1 it is forced to 0 if a committed write to that address occurs this cycle and mark does not target it.
- ZERO_REG=0: reg 0 behaves as an ordinary register.
- No X on outputs for any input combination once reset has been applied.

Test Plan:
1. Assert rst mid-run after writing 0xDEADBEEF to x5 and marking x6 busy -> while rst is high, read_data=0 for x5 and read_busy=0 for x6, without waiting for a clk edge.
2. Write x3=0x12345678 on port 0, read x3 on both read ports in the same cycle. BYPASS=1 -> 0x12345678 in the same cycle. BYPASS=0 -> old value 0, then 0x12345678 the next cycle.
3. Ports 0 and 1 write x7 with 0xAAAA0000 and 0x0000BBBB in the same cycle -> x7 = 0x0000BBBB afterwards; the bypassed read also shows 0x0000BBBB.
4. Write 0xFFFFFFFF to x0 and mark x0 busy -> x0 reads 0 and read_busy=0, both in the same cycle and the next.
5. Mark x9 busy -> read_busy=1 the next cycle. Write x9=0x55 -> read_busy=0 the same cycle (bypass) and stays 0. In one cycle, write x9 and mark x9 -> read_busy=1 afterwards.
6. NREGS=16 with AW=5: write to address 20 -> ignored; read of address 20 returns 0 with read_busy=0. NREAD=4 and NWRITE=1: all four ports read distinct registers correctly.
